multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Parametrised multicycle RV32I control unit for the shared-memory datapath; one Moore FSM.
//  Sequences fetch/decode/execute/writeback, raises datapath strobes and mux selects per state.
//  Waits on memory handshake, supports jalr/lui/auipc/bne and traps illegal opcodes.
//  Sits beside the multicycle datapath; ALU op comes from the existing alu_decoder.
// PARAMETERS
//  ALU_CTRL_W     3  alu_control width; >=3; decoder result zero-extended into upper bits
//  EN_UPPER       1  1: lui/auipc legal; 0: both opcodes trap
//  EN_JALR        1  1: jalr legal; 0: jalr traps
//  MEM_HANDSHAKE  1  1: memory states wait for mem_ready; 0: mem_ready ignored, treated as 1
// PORTS
//  clk          in   1           clock, rising edge
//  rst_n        in   1           synchronous active-low reset
//  instr        in   32          IR contents (opcode[6:0], funct3[14:12], funct7_5[30])
//  zero         in   1           ALU zero flag
//  mem_ready    in   1           memory access completes this cycle
//  pc_write     out  1           PC <= result
//  ir_write     out  1           IR/OldPC <= read data/PC
//  adr_src      out  1           0: PC, 1: result
//  mem_read     out  1           memory read request
//  mem_write    out  1           memory write request
//  reg_write    out  1           register file write
//  result_src   out  2           00: ALUOut, 01: Data, 10: ALUResult
//  alu_src_a    out  2           00: PC, 01: OldPC, 10: rs1, 11: zero
//  alu_src_b    out  2           00: rs2, 01: imm, 10: const 4
//  imm_src      out  3           000 I, 001 S, 010 B, 011 J, 100 U (opcode-decoded every cycle)
//  alu_control  out  ALU_CTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt
//  illegal      out  1           sticky trap flag
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state<=FETCH, illegal<=0. While rst_n=0, all strobes are 0 combinationally.
//  Unlisted outputs are 0; alu add unless stated. Strobes: pc_write, ir_write, mem_*, reg_write.
//  FETCH: adr_src 0, mem_read 1, a=00, b=10, result_src 10.
//    ir_write and pc_write assert only when mem_ready. Stays in FETCH until mem_ready.
//  DECODE: a=01, b=01 (ALUOut <= branch/jal target). Next state by opcode:
//    0000011/0100011 MEMADR; 0110011 EXECR; 0010011 EXECI; 1100011 BRANCH; 1101111 JAL;
//    1100111 JALRADR; 0110111/0010111 UPPER; anything else (or disabled by parameter) TRAP.
//  MEMADR: a=10, b=01. lw -> MEMREAD, sw -> MEMWRITE.
//  MEMREAD: adr_src 1, result_src 00, mem_read 1. Wait for mem_ready, then MEMWB.
//  MEMWB: result_src 01, reg_write 1 -> FETCH.
//  MEMWRITE: adr_src 1, result_src 00, mem_write 1. Wait for mem_ready, then FETCH.
//  EXECR: a=10, b=00, alu_control from alu_decoder (alu_op=10) -> ALUWB.
//  EXECI: a=10, b=01, same decoder path -> ALUWB.
//  ALUWB: result_src 00, reg_write 1 -> FETCH.
//  BRANCH: a=10, b=00, sub, result_src 00. pc_write = zero ^ funct3[0] (beq/bne) -> FETCH.
//  JALRADR: a=10, b=01 (ALUOut <= rs1+imm) -> JAL.
//  JAL: a=01, b=10, result_src 00, pc_write 1 -> ALUWB (rd <= OldPC+4).
//  UPPER: lui a=11, b=01; auipc a=01, b=01 -> ALUWB.
//  TRAP: all strobes 0, illegal=1. Exits only via reset.
//  Wait states: mem_read/mem_write, adr_src and selects stay stable until mem_ready; no strobe repeats.
//  Latency with mem_ready=1 (cycles): branch 3; R/I/sw/jal/lui/auipc 4; lw/jalr 5.
//  Reset mid-wait abandons the access; the first post-reset cycle is FETCH.
//  Unsupported funct3 inside a legal opcode is not trapped (decoder default).
// STRUCTURE
//  cpu_pkg: state_t enum, opcode localparams, result/src_a/src_b/imm_src encodings.
//  Sub-module: existing alu_decoder instance, output zero-extended to ALU_CTRL_W.
//  One always_ff for state/illegal; one always_comb for next state and outputs.
// TESTING
//  add x3,x1,x2, mem_ready=1 -> states F,D,EXECR,ALUWB; reg_write only in cycle 4, alu_control=000.
//  lw, mem_ready low 3 cycles in MEMREAD -> mem_read held 3+1 cycles; MEMWB after ready; total 8 cycles.
//  beq with zero=1, then bne with zero=1 -> pc_write=1 in BRANCH, then pc_write=0; both return to FETCH.
//  jalr, EN_JALR=1 -> JALRADR (a=10, b=01), JAL pc_write, ALUWB reg_write; 5 cycles.
//  jalr, EN_JALR=0 -> TRAP.
//  opcode 0x7F -> TRAP, illegal=1 held 20 cycles with no strobes; rst_n=0 one edge -> FETCH, illegal=0.
//  MEM_HANDSHAKE=0, mem_ready tied 0 -> sw completes in 4 cycles; reset during MEMWRITE wait -> mem_write=0 at once.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JALRADR,
        S_JAL,
        S_UPPER,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate format selected purely from the opcode.
    function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:        return IMM_S;
            OP_BRANCH:       return IMM_B;
            OP_JAL:          return IMM_J;
            OP_LUI, OP_AUIPC: return IMM_U;
            default:         return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decoder: alu_op plus funct fields to a 3-bit ALU control code.
module multicycle_control_alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op_5,
    output logic [2:0] alu_control_c
);

    // Unsupported funct3 values fall back to add rather than trapping.
    always_comb begin
        alu_control_c = ALU_ADD;
        case (alu_op)
            ALU_OP_SUB: alu_control_c = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control_c = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_c = ALU_SLT;
                    3'b110:  alu_control_c = ALU_OR;
                    3'b111:  alu_control_c = ALU_AND;
                    default: alu_control_c = ALU_ADD;
                endcase
            end
            default: alu_control_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the shared-memory multicycle RV32I datapath.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W    = 3,
    parameter bit          EN_UPPER      = 1'b1,
    parameter bit          EN_JALR       = 1'b1,
    parameter bit          MEM_HANDSHAKE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  adr_src,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [2:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal
);

    state_t      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [1:0]  alu_op_c;
    logic [2:0]  alu_ctrl_c;
    logic [6:0]  opcode;
    logic        mem_ready_c;
    logic        unused_instr_bits;

    assign opcode            = instr[6:0];
    assign mem_ready_c       = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};
    assign illegal           = illegal_q;
    assign alu_control       = ALU_CTRL_W'(alu_ctrl_c);

    multicycle_control_alu_decoder u_alu_decoder (
        .alu_op        (alu_op_c),
        .funct3        (instr[14:12]),
        .funct7_5      (instr[30]),
        .op_5          (instr[5]),
        .alu_control_c (alu_ctrl_c)
    );

    // State and sticky trap flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op_c   = ALU_OP_ADD;
        imm_src    = imm_src_of(opcode);

        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (mem_ready_c) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = EN_JALR ? S_JALRADR : S_TRAP;
                    OP_LUI, OP_AUIPC:  state_d = EN_UPPER ? S_UPPER : S_TRAP;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (mem_ready_c) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready_c) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op_c  = ALU_OP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op_c  = ALU_OP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op_c  = ALU_OP_SUB;
                pc_write  = zero ^ instr[12];
                state_d   = S_FETCH;
            end
            S_JALRADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = S_JAL;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_UPPER: begin
                alu_src_a = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                state_d   = S_ALUWB;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        illegal_d = illegal_q || (state_d == S_TRAP);

        // No side effects while reset is held.
        if (!rst_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule
